// File: rtl/device_rw_if.sv
// Packet-level handshake between the device packet layer (master) and the
// read/write responder (slave).
interface device_rw_if;
  logic        out_valid;
  logic        out_ok;
  logic [63:0] out_data;
  logic        in_req;
  logic        ack;
  logic        nak;
  logic        in_valid;
  logic [63:0] in_data;
  logic        write_done;
  logic        timeout;
  logic        busy;
  logic [15:0] page;

  modport slave (
    input  out_valid, out_ok, out_data, in_req,
    output ack, nak, in_valid, in_data, write_done, timeout, busy, page
  );

  modport master (
    output out_valid, out_ok, out_data, in_req,
    input  ack, nak, in_valid, in_data, write_done, timeout, busy, page
  );
endinterface

// File: rtl/device_rw_responder.sv
// Device endpoint answering the host address/data/read packet sequence,
// backed by a DEPTH x 64-bit page memory; every strobe gets one ack or nak.
module device_rw_responder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst_b,
  device_rw_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [16:0]   DEPTH_LIM  = 17'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ADDR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [15:0]   page_q, page_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_q, ack_d;
  logic          nak_q, nak_d;
  logic          in_valid_q, in_valid_d;
  logic [63:0]   in_data_q, in_data_d;
  logic          write_done_q, write_done_d;
  logic          timeout_q, timeout_d;
  logic          mem_we;
  logic [63:0]   mem_q [DEPTH];

  logic [IDX_W-1:0] page_idx;
  logic             addr_in_range;

  // page_q only ever holds an in-range index, so its low bits address memory.
  assign page_idx      = page_q[IDX_W-1:0];
  assign addr_in_range = ({1'b0, bus.out_data[15:0]} < DEPTH_LIM);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d      = state_q;
    page_d       = page_q;
    timer_d      = timer_q;
    ack_d        = 1'b0;
    nak_d        = 1'b0;
    in_valid_d   = 1'b0;
    in_data_d    = in_data_q;
    write_done_d = 1'b0;
    timeout_d    = 1'b0;
    mem_we       = 1'b0;

    if (bus.out_valid && bus.in_req) begin
      // Both strobes at once is a protocol error regardless of state.
      nak_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.out_valid) begin
            if (bus.out_ok && addr_in_range) begin
              page_d  = bus.out_data[15:0];
              ack_d   = 1'b1;
              timer_d = '0;
              state_d = S_ADDR;
            end else begin
              nak_d = 1'b1;
            end
          end else if (bus.in_req) begin
            nak_d = 1'b1;
          end
        end
        S_ADDR: begin
          if (bus.out_valid) begin
            state_d = S_IDLE;
            if (bus.out_ok) begin
              mem_we       = 1'b1;
              ack_d        = 1'b1;
              write_done_d = 1'b1;
            end else begin
              nak_d = 1'b1;
            end
          end else if (bus.in_req) begin
            in_data_d  = mem_q[page_idx];
            in_valid_d = 1'b1;
            ack_d      = 1'b1;
            state_d    = S_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      page_q       <= '0;
      timer_q      <= '0;
      ack_q        <= 1'b0;
      nak_q        <= 1'b0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      write_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      timer_q      <= timer_d;
      ack_q        <= ack_d;
      nak_q        <= nak_d;
      in_valid_q   <= in_valid_d;
      in_data_q    <= in_data_d;
      write_done_q <= write_done_d;
      timeout_q    <= timeout_d;
    end
  end

  // NOTE: the page memory is flop-based and must read back zero after reset,
  // so it sits on the async reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[page_idx] <= bus.out_data;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.nak        = nak_q;
  assign bus.in_valid   = in_valid_q;
  assign bus.in_data    = in_data_q;
  assign bus.write_done = write_done_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = (state_q == S_ADDR);
  assign bus.page       = page_q;

endmodule

// File: tb/tb_device_rw_responder.sv
// Self-checking bench for device_rw_responder: directed protocol scenarios
// followed by randomized traffic, all scored against a transaction-level model.
module tb_device_rw_responder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 200;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  device_rw_if bus ();

  device_rw_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "is an address pending", how long it has waited, and
  // the contents the host has written so far.
  bit          m_pending;
  int          m_wait;
  logic [15:0] m_page;
  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_in_data;
  bit e_ack, e_nak, e_in_valid, e_write_done, e_timeout;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_wait    = 0;
    m_page    = '0;
    m_in_data = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    {e_ack, e_nak, e_in_valid, e_write_done, e_timeout} = '0;
  endtask

  task automatic model_step(input logic ov, input logic ok, input logic [63:0] data,
                            input logic ir);
    {e_ack, e_nak, e_in_valid, e_write_done, e_timeout} = '0;
    if (ov && ir) begin
      e_nak     = 1;
      m_pending = 0;
    end else if (!m_pending) begin
      if (ov) begin
        if (ok && int'(data[15:0]) < DEPTH) begin
          m_page    = data[15:0];
          m_pending = 1;
          m_wait    = 0;
          e_ack     = 1;
        end else begin
          e_nak = 1;
        end
      end else if (ir) begin
        e_nak = 1;
      end
    end else if (ov) begin
      m_pending = 0;
      if (ok) begin
        m_mem[m_page] = data;
        e_ack         = 1;
        e_write_done  = 1;
      end else begin
        e_nak = 1;
      end
    end else if (ir) begin
      m_in_data  = m_mem[m_page];
      e_in_valid = 1;
      e_ack      = 1;
      m_pending  = 0;
    end else begin
      m_wait++;
      if (m_wait == TIMEOUT) begin
        e_timeout = 1;
        m_pending = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("flags",
          64'({bus.ack, bus.nak, bus.in_valid, bus.write_done, bus.timeout, bus.busy}),
          64'({e_ack, e_nak, e_in_valid, e_write_done, e_timeout, m_pending}));
    check("page", 64'(bus.page), 64'(m_page));
    check("in_data", bus.in_data, m_in_data);
  endtask

  // Present one cycle of stimulus, then score the registered response.
  task automatic cycle(input logic ov, input logic ok, input logic [63:0] data,
                       input logic ir);
    bus.out_valid = ov;
    bus.out_ok    = ok;
    bus.out_data  = data;
    bus.in_req    = ir;
    @(posedge clk);
    model_step(ov, ok, data, ir);
    #1;
    compare_outputs();
    @(negedge clk);
    bus.out_valid = 1'b0;
    bus.out_ok    = 1'b0;
    bus.out_data  = '0;
    bus.in_req    = 1'b0;
  endtask

  task automatic addr(input logic [15:0] p);
    cycle(1'b1, 1'b1, {48'h0, p}, 1'b0);
  endtask

  task automatic rd();
    cycle(1'b0, 1'b0, 64'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    bus.out_valid = 1'b0;
    bus.out_ok    = 1'b0;
    bus.out_data  = '0;
    bus.in_req    = 1'b0;
    model_reset();

    #12;
    compare_outputs();
    @(negedge clk);
    rst_b = 1'b1;

    // Write then read back.
    addr(16'h0005);
    check("busy_after_addr", 64'(bus.busy), 64'd1);
    cycle(1'b1, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    check("write_done", 64'(bus.write_done), 64'd1);
    addr(16'h0005);
    rd();
    check("wr_rd_data", bus.in_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("busy_after_rd", 64'(bus.busy), 64'd0);

    // Range / CRC / stray IN rejection.
    addr(16'h0010);
    check("range_nak", 64'(bus.nak), 64'd1);
    cycle(1'b1, 1'b0, 64'h3, 1'b0);
    rd();
    check("idle_rd_no_valid", 64'(bus.in_valid), 64'd0);

    // Corrupt data phase leaves memory untouched.
    addr(16'h0002);
    cycle(1'b1, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
    addr(16'h0002);
    rd();
    check("corrupt_keep", bus.in_data, 64'h0);

    // Timeout after exactly TIMEOUT idle cycles, then a stray read.
    addr(16'h0001);
    idle(TIMEOUT);
    check("timeout_pulse", 64'(bus.timeout), 64'd1);
    rd();

    // A strobe on the expiry cycle is serviced and suppresses the timeout.
    addr(16'h0005);
    idle(TIMEOUT - 1);
    rd();
    check("expiry_strobe_data", bus.in_data, 64'hDEAD_BEEF_CAFE_F00D);

    // Simultaneous strobes in ADDR.
    addr(16'h0003);
    cycle(1'b1, 1'b1, 64'h5555_AAAA_5555_AAAA, 1'b1);
    addr(16'h0003);
    rd();

    // Asynchronous reset in the middle of a transaction.
    addr(16'h0007);
    cycle(1'b1, 1'b1, 64'h1234, 1'b0);
    addr(16'h0007);
    #2 rst_b = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk);
    rst_b = 1'b1;
    addr(16'h0007);
    rd();
    check("reset_clears", bus.in_data, 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [63:0] d;
      sel = $urandom_range(99);
      d   = {$urandom, $urandom};
      if (sel < 35) begin
        cycle(1'b0, 1'b0, 64'h0, 1'b0);
      end else if (sel < 55) begin
        cycle(1'b1, ($urandom_range(9) != 0), {d[63:16], 16'($urandom_range(19))}, 1'b0);
      end else if (sel < 70) begin
        cycle(1'b1, ($urandom_range(9) != 0), d, 1'b0);
      end else if (sel < 95) begin
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
      end else begin
        cycle(1'b1, 1'($urandom_range(1)), d, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
